mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive fetch denials before fetch is forced to win.
REQ-002 SHALL have ports `clk` (in, 1): single clock, all logic on rising edge; synchronous reset sampled on this edge.
REQ-003 SHALL have port `rst_ni` (in, 1): reset, synchronous, active-low.
REQ-004 SHALL have ports `if_req_i` (in, 1) and `if_addr_i` (in, 64): instruction-fetch request and byte address.
REQ-005 SHALL have ports `if_gnt_o` (out, 1), `if_rvalid_o` (out, 1) and `if_rdata_o` (out, 32): fetch grant, response valid and instruction word.
REQ-006 SHALL have ports `d_req_i` (in, 1), `d_we_i` (in, 1), `d_be_i` (in, 8), `d_addr_i` (in, 64) and `d_wdata_i` (in, 64): LSU request.
REQ-007 SHALL have ports `d_gnt_o` (out, 1), `d_rvalid_o` (out, 1) and `d_rdata_o` (out, 64): LSU grant, response valid and read data.
REQ-008 SHALL have ports `mem_req_o` (out, 1), `mem_we_o` (out, 1), `mem_be_o` (out, 8), `mem_addr_o` (out, 64) and `mem_wdata_o` (out, 64): single-port memory request.
REQ-009 SHALL have port `mem_rdata_i` (in, 64): memory read data, valid exactly one cycle after an accepted read.

Function
REQ-010 SHALL grant at most one requester per cycle; a grant is combinational from the same-cycle req (gnt = accept).
REQ-011 SHALL drive mem_req_o = if_gnt_o | d_gnt_o; the memory port carries the granted requester's fields.
- mem_addr_o SHALL be the granted address with bits [2:0] forced to 0.
REQ-012 SHALL drive the fetch request as mem_we_o=0 and mem_be_o=8'hFF; the LSU request SHALL pass d_we_i/d_be_i/d_wdata_i through unchanged.
REQ-013 SHALL drive mem_we_o, mem_be_o and mem_wdata_o to 0 when no grant is given.
REQ-014 SHALL keep a two-state FSM: IDLE (no response pending) and RESP (response due this cycle).
- Any grant SHALL move the FSM to RESP.
- RESP without a new grant SHALL return to IDLE.
- RESP with a new grant SHALL stay in RESP, giving back-to-back throughput of 1 request/cycle.
REQ-015 SHALL register, at grant, the owner (IF/D), whether it was a write, and if_addr_i[2].
REQ-016 SHALL, in RESP, pulse the owner's rvalid for exactly one cycle (latency 1 cycle from grant, data reads and writes alike).
REQ-017 SHALL present if_rdata_o = mem_rdata_i[63:32] if the registered addr[2]=1, else mem_rdata_i[31:0].
- if_addr_i[1:0] SHALL be ignored.
REQ-018 SHALL present d_rdata_o = mem_rdata_i for reads and 64'h0 for write acknowledgements.
- rdata outputs SHALL be 0 when their rvalid is low.
REQ-019 SHALL, on simultaneous requests, grant d unless the starvation guard (REQ-026) forces IF.
REQ-020 SHALL allow a requester to drop req before gnt with no side effect; an ungranted req carries no state.

Reset
REQ-021 SHALL, while rst_ni=0 at a rising clk edge, set the FSM to IDLE, the starvation counter to 0 and the registered owner/we/addr[2] to 0.
REQ-022 SHALL hold all grants, rvalids, mem_req_o and data outputs at 0 in the cycle reset is asserted, including combinational grants.
REQ-023 SHALL discard a response pending when reset is asserted mid-operation; no rvalid after reset deassertion without a new grant.

Configuration
REQ-024 SHALL compile the starvation guard in only when macro MEM_ARB_STARVE_GUARD_EN is defined.
REQ-025 SHALL, without MEM_ARB_STARVE_GUARD_EN, apply strict data priority; STARVE_MAX is unused and fetch may starve indefinitely.
REQ-026 SHALL, with MEM_ARB_STARVE_GUARD_EN, maintain the starvation counter as follows.
- The counter SHALL increment (saturating at STARVE_MAX) each cycle if_req_i=1 and if_gnt_o=0.
- The counter SHALL clear when fetch is granted or if_req_i=0.
- When counter==STARVE_MAX and if_req_i=1, fetch SHALL win over d.

Structure
REQ-027 SHALL place the owner enum (OWN_IF, OWN_D), the FSM state enum and the STARVE_MAX default in shared package mem_arb_pkg.
REQ-028 SHALL implement the starvation counter as one sub-module, mem_arb_starve_cnt, instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-029 SHALL cover a lone fetch read.
- Stimulus: if_req_i=1, if_addr_i=0x104, memory word 0x11223344_AABBCCDD.
- Response: if_gnt_o=1 same cycle, mem_addr_o=0x100; next cycle if_rvalid_o=1 with if_rdata_o=0x11223344.
REQ-030 SHALL cover an LSU write.
- Stimulus: d_we_i=1, d_be_i=0x0F, d_addr_i=0x208, d_wdata_i=0xDEADBEEF.
- Response: mem_we_o=1, mem_be_o=0x0F, mem_addr_o=0x208; next cycle d_rvalid_o=1 with d_rdata_o=0.
REQ-031 SHALL cover a simultaneous request without the macro: both req held 3 cycles -> d_gnt_o=1 every cycle, if_gnt_o never asserts.
REQ-032 SHALL cover a simultaneous request with the macro and STARVE_MAX=4: both req held continuously -> d granted 4 cycles, IF granted on the 5th, pattern repeats.
REQ-033 SHALL cover back-to-back alternation: IF granted cycle N, d granted N+1 -> if_rvalid_o at N+1, d_rvalid_o at N+2, never both in the same cycle.
REQ-034 SHALL cover reset mid-operation: rst_ni=0 in the cycle after a d grant -> d_rvalid_o stays 0, and after release all outputs stay 0 until the next req.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the fetch/LSU memory arbiter
package mem_arb_pkg;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  typedef enum logic {IDLE, RESP} state_t;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt: counts consecutive fetch denials and forces a fetch win at STARVE_MAX
// Ports: clk, rst_ni (sync active-low), if_req/if_gnt (fetch request and grant), force_if (fetch must win now)
module mem_arb_starve_cnt import mem_arb_pkg::*; #(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);
  localparam int W = STARVE_MAX < 1 ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [W-1:0] MAX = W'(STARVE_MAX);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_ni) cnt <= '0;
    else if (!if_req || if_gnt) cnt <= '0;
    else if (cnt != MAX) cnt <= cnt + 1'b1;
  end
  assign force_if = if_req && cnt == MAX;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetch and LSU onto one single-port 64-bit memory
// Ports: clk, rst_ni (sync active-low); if_* fetch request/grant/response (32-bit word);
//        d_* LSU request/grant/response (64-bit); mem_* memory request, mem_rdata_i one cycle later.
// Build option: define MEM_ARB_STARVE_GUARD_EN to let fetch win after STARVE_MAX straight denials;
//        otherwise the LSU always has priority.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [7:0]  d_be_i,
  input  logic [63:0] d_addr_i,
  input  logic [63:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [63:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_be_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic [63:0] mem_rdata_i
);
  state_t state, state_nxt;
  owner_t owner;
  logic   we_q, a2_q, force_if, unused_bits;
`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk), .rst_ni(rst_ni), .if_req(if_req_i), .if_gnt(if_gnt_o), .force_if(force_if)
  );
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign force_if = 1'b0;
`endif
  assign unused_bits = ^if_addr_i[1:0] ^ ^d_addr_i[2:0];
  // grants are gated by rst_ni so nothing reaches memory in a reset cycle
  assign d_gnt_o     = rst_ni && d_req_i && !force_if;
  assign if_gnt_o    = rst_ni && if_req_i && !d_gnt_o;
  assign mem_req_o   = if_gnt_o || d_gnt_o;
  assign mem_we_o    = d_gnt_o && d_we_i;
  assign mem_be_o    = d_gnt_o ? d_be_i : if_gnt_o ? 8'hFF : 8'h00;
  assign mem_addr_o  = d_gnt_o ? {d_addr_i[63:3], 3'b000} : if_gnt_o ? {if_addr_i[63:3], 3'b000} : 64'h0;
  assign mem_wdata_o = d_gnt_o ? d_wdata_i : 64'h0;
  always_ff @(posedge clk) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      owner <= OWN_IF;
      we_q  <= 1'b0;
      a2_q  <= 1'b0;
    end else if (mem_req_o) begin
      owner <= d_gnt_o ? OWN_D : OWN_IF;
      we_q  <= d_gnt_o && d_we_i;
      a2_q  <= if_addr_i[2];
    end
  end
  always_comb state_nxt = mem_req_o ? RESP : IDLE;
  always_comb begin
    if_rvalid_o = rst_ni && state == RESP && owner == OWN_IF;
    d_rvalid_o  = rst_ni && state == RESP && owner == OWN_D;
    if_rdata_o  = !if_rvalid_o ? 32'h0 : a2_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    d_rdata_o   = d_rvalid_o && !we_q ? mem_rdata_i : 64'h0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
  logic [63:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0, mem_rdata_i = '0;
  logic [7:0]  d_be_i = '0;
  logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o;
  logic [31:0] if_rdata_o;
  logic [63:0] d_rdata_o, mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_be_o;
  int passed = 0, total = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // advance to the next negedge, apply new inputs there and settle for 1ns before checking
  task automatic step(input logic ir, input logic [63:0] ia, input logic dr, input logic dw,
                      input logic [7:0] be, input logic [63:0] da, input logic [63:0] wd);
    @(negedge clk);
    if_req_i = ir; if_addr_i = ia; d_req_i = dr; d_we_i = dw; d_be_i = be; d_addr_i = da; d_wdata_i = wd;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1, 64'h104, 1, 1, 8'hFF, 64'h208, 64'h1);
    total++; if (if_gnt_o !== 1'b0) $display("FAIL reset_if_gnt got %b exp 0", if_gnt_o); else passed++;
    total++; if (d_gnt_o !== 1'b0) $display("FAIL reset_d_gnt got %b exp 0", d_gnt_o); else passed++;
    total++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_be_o !== 8'h0 || mem_wdata_o !== 64'h0)
      $display("FAIL reset_mem got req=%b we=%b be=%h wd=%h exp all 0", mem_req_o, mem_we_o, mem_be_o, mem_wdata_o);
    else passed++;
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0 || d_rdata_o !== 64'h0)
      $display("FAIL reset_resp got ifv=%b dv=%b ifd=%h dd=%h exp all 0", if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o);
    else passed++;
    rst_ni = 1'b1;
    idle(1);
    total++; if (if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0)
      $display("FAIL reset_release_rvalid got if=%b d=%b exp 0 0", if_rvalid_o, d_rvalid_o);
    else passed++;
  endtask

  task automatic test_fetch_read;
    mem_rdata_i = 64'h11223344_AABBCCDD;
    step(1, 64'h104, 0, 0, 0, 0, 0);
    total++; if (if_gnt_o !== 1'b1 || d_gnt_o !== 1'b0) $display("FAIL fetch_gnt got if=%b d=%b exp 1 0", if_gnt_o, d_gnt_o); else passed++;
    total++; if (mem_addr_o !== 64'h100 || mem_we_o !== 1'b0 || mem_be_o !== 8'hFF || mem_req_o !== 1'b1)
      $display("FAIL fetch_mem got addr=%h we=%b be=%h req=%b exp 100 0 ff 1", mem_addr_o, mem_we_o, mem_be_o, mem_req_o);
    else passed++;
    step(1, 64'h103, 0, 0, 0, 0, 0);
    total++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h11223344 || d_rvalid_o !== 1'b0)
      $display("FAIL fetch_hi_resp got v=%b d=%h dv=%b exp 1 11223344 0", if_rvalid_o, if_rdata_o, d_rvalid_o);
    else passed++;
    total++; if (mem_addr_o !== 64'h100) $display("FAIL fetch_lo_addr got %h exp 100", mem_addr_o); else passed++;
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hAABBCCDD)
      $display("FAIL fetch_lo_resp got v=%b d=%h exp 1 aabbccdd", if_rvalid_o, if_rdata_o);
    else passed++;
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0)
      $display("FAIL fetch_single_pulse got v=%b d=%h exp 0 0", if_rvalid_o, if_rdata_o);
    else passed++;
  endtask

  task automatic test_lsu;
    mem_rdata_i = 64'hCAFEF00D_12345678;
    step(0, 0, 1, 1, 8'h0F, 64'h208, 64'hDEADBEEF);
    total++; if (d_gnt_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 8'h0F || mem_addr_o !== 64'h208 || mem_wdata_o !== 64'hDEADBEEF)
      $display("FAIL lsu_write_mem got g=%b we=%b be=%h a=%h wd=%h exp 1 1 0f 208 deadbeef", d_gnt_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    else passed++;
    step(0, 0, 1, 0, 8'hF0, 64'h20D, 64'h5);
    total++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 64'h0 || if_rvalid_o !== 1'b0)
      $display("FAIL lsu_write_ack got v=%b d=%h ifv=%b exp 1 0 0", d_rvalid_o, d_rdata_o, if_rvalid_o);
    else passed++;
    total++; if (mem_we_o !== 1'b0 || mem_addr_o !== 64'h208 || mem_be_o !== 8'hF0 || mem_wdata_o !== 64'h5)
      $display("FAIL lsu_read_mem got we=%b a=%h be=%h wd=%h exp 0 208 f0 5", mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o);
    else passed++;
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 64'hCAFEF00D_12345678)
      $display("FAIL lsu_read_resp got v=%b d=%h exp 1 cafef00d12345678", d_rvalid_o, d_rdata_o);
    else passed++;
    total++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_be_o !== 8'h0 || mem_wdata_o !== 64'h0)
      $display("FAIL idle_mem got req=%b we=%b be=%h wd=%h exp all 0", mem_req_o, mem_we_o, mem_be_o, mem_wdata_o);
    else passed++;
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (d_rvalid_o !== 1'b0 || d_rdata_o !== 64'h0)
      $display("FAIL lsu_single_pulse got v=%b d=%h exp 0 0", d_rvalid_o, d_rdata_o);
    else passed++;
  endtask

  task automatic test_priority;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 10; i++) begin
      step(1, 64'h40, 1, 0, 8'hFF, 64'h80, 0);
      total++; if (if_gnt_o !== (i % 5 == 4) || d_gnt_o !== (i % 5 != 4))
        $display("FAIL starve_cycle%0d got if=%b d=%b exp %b %b", i, if_gnt_o, d_gnt_o, i % 5 == 4, i % 5 != 4);
      else passed++;
    end
`else
    for (int i = 0; i < 3; i++) begin
      step(1, 64'h40, 1, 0, 8'hFF, 64'h80, 0);
      total++; if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0 || mem_addr_o !== 64'h80)
        $display("FAIL strict_prio_cycle%0d got d=%b if=%b a=%h exp 1 0 80", i, d_gnt_o, if_gnt_o, mem_addr_o);
      else passed++;
    end
`endif
    idle(2);
  endtask

  task automatic test_back_to_back;
    mem_rdata_i = 64'h11223344_AABBCCDD;
    step(1, 64'h104, 0, 0, 0, 0, 0);
    total++; if (if_gnt_o !== 1'b1) $display("FAIL b2b_if_gnt got %b exp 1", if_gnt_o); else passed++;
    step(0, 0, 1, 0, 8'hFF, 64'h300, 0);
    total++; if (d_gnt_o !== 1'b1 || if_rvalid_o !== 1'b1 || d_rvalid_o !== 1'b0 || if_rdata_o !== 32'h11223344)
      $display("FAIL b2b_n1 got dg=%b ifv=%b dv=%b ifd=%h exp 1 1 0 11223344", d_gnt_o, if_rvalid_o, d_rvalid_o, if_rdata_o);
    else passed++;
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (d_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0 || d_rdata_o !== 64'h11223344_AABBCCDD || if_rdata_o !== 32'h0)
      $display("FAIL b2b_n2 got dv=%b ifv=%b dd=%h ifd=%h exp 1 0 11223344aabbccdd 0", d_rvalid_o, if_rvalid_o, d_rdata_o, if_rdata_o);
    else passed++;
    idle(1);
  endtask

  task automatic test_reset_mid;
    mem_rdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
    step(0, 0, 1, 0, 8'hFF, 64'h400, 0);
    total++; if (d_gnt_o !== 1'b1) $display("FAIL mid_d_gnt got %b exp 1", d_gnt_o); else passed++;
    rst_ni = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (d_rvalid_o !== 1'b0 || d_rdata_o !== 64'h0)
      $display("FAIL mid_rst_rvalid got v=%b d=%h exp 0 0", d_rvalid_o, d_rdata_o);
    else passed++;
    rst_ni = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      total++; if (d_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0 || mem_req_o !== 1'b0 || d_rdata_o !== 64'h0 || if_rdata_o !== 32'h0)
        $display("FAIL mid_after_rst%0d got dv=%b ifv=%b req=%b dd=%h ifd=%h exp all 0", i, d_rvalid_o, if_rvalid_o, mem_req_o, d_rdata_o, if_rdata_o);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_fetch_read;
    test_lsu;
    test_priority;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
